// File: rtl/wb_gpo_regs.sv
// Wishbone classic slave driving a DW-bit output register with write/set/clear/toggle modes.
// Optional macro WB_GPO_OE_EN adds an output-enable register (OE_O) at word address 6.
module wb_gpo_regs #(
  parameter int              DW     = 32,
  parameter logic [DW-1:0]   S_INIT = '0
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              CYC_I,
  input  logic              STB_I,
  input  logic              WE_I,
  input  logic [2:0]        ADR_I,
  input  logic [DW/8-1:0]   SEL_I,
  input  logic [DW-1:0]     DAT_I,
  output logic [DW-1:0]     DAT_O,
  output logic              ACK_O,
`ifdef WB_GPO_OE_EN
  output logic [DW-1:0]     OE_O,
`endif
  output logic [DW-1:0]     S
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UPD  = 2'b01,
    ACK  = 2'b10
  } state_e;

  state_e            state_q;
  logic [2:0]        adr_q;
  logic [DW/8-1:0]   sel_q;
  logic [DW-1:0]     dat_q;
  logic [DW-1:0]     s_q;
  logic [DW-1:0]     s_d;
  logic [DW-1:0]     laneMask;
  logic [DW-1:0]     sVisible;
  logic [DW-1:0]     rdData;

`ifdef WB_GPO_OE_EN
  logic [DW-1:0]     oe_q;
  logic [DW-1:0]     oe_d;

  assign OE_O     = oe_q;
  assign sVisible = s_q & oe_q;
`else
  assign sVisible = s_q;
`endif

  assign S = s_q;

  always_comb begin
    laneMask = '0;
    for (int k = 0; k < DW/8; k++) begin
      laneMask[8*k +: 8] = {8{sel_q[k]}};
    end
  end

  // Next value of S from the captured write; only meaningful while in UPD.
  always_comb begin
    s_d = s_q;
    case (adr_q)
      3'd0:    s_d = (s_q & ~laneMask) | (dat_q & laneMask);
      3'd1:    s_d = s_q | (dat_q & laneMask);
      3'd2:    s_d = s_q & ~(dat_q & laneMask);
      3'd3:    s_d = s_q ^ (dat_q & laneMask);
      default: s_d = s_q;
    endcase
  end

`ifdef WB_GPO_OE_EN
  always_comb begin
    oe_d = oe_q;
    if (adr_q == 3'd6) begin
      oe_d = (oe_q & ~laneMask) | (dat_q & laneMask);
    end
  end
`endif

  always_comb begin
    rdData = '0;
    case (ADR_I)
      3'd0, 3'd1, 3'd2, 3'd3: rdData = sVisible;
      3'd4:                   rdData[7:0] = 8'hA5;
`ifdef WB_GPO_OE_EN
      3'd6:                   rdData = oe_q;
`endif
      default:                rdData = '0;
    endcase
  end

  // Writes take IDLE->UPD->ACK, reads IDLE->ACK; ACK_O is registered on entry to ACK.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      s_q     <= S_INIT;
      DAT_O   <= '0;
      ACK_O   <= 1'b0;
`ifdef WB_GPO_OE_EN
      oe_q    <= '0;
`endif
    end else begin
      ACK_O <= 1'b0;
      case (state_q)
        IDLE: begin
          if (CYC_I && STB_I) begin
            if (WE_I) begin
              state_q <= UPD;
              adr_q   <= ADR_I;
              sel_q   <= SEL_I;
              dat_q   <= DAT_I;
            end else begin
              state_q <= ACK;
              DAT_O   <= rdData;
              ACK_O   <= 1'b1;
            end
          end
        end
        UPD: begin
          s_q     <= s_d;
`ifdef WB_GPO_OE_EN
          oe_q    <= oe_d;
`endif
          state_q <= ACK;
          ACK_O   <= 1'b1;
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_gpo_regs.sv
// Directed testbench for wb_gpo_regs with a scoreboard queue of expected responses.
// Also covers the OE register when compiled with WB_GPO_OE_EN.
module tb_wb_gpo_regs;

  localparam int MODE_NORMAL   = 0;
  localparam int MODE_SCRAMBLE = 1;
  localparam int MODE_DROP     = 2;

  logic        CLK_I;
  logic        RST_I;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic [2:0]  ADR_I;
  logic [3:0]  SEL_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic [31:0] S;
`ifdef WB_GPO_OE_EN
  logic [31:0] OE_O;
`endif

  typedef struct {
    string       tag;
    bit          isRead;
    logic [31:0] expData;
    int          expLat;
  } expT;

  expT         sbQ[$];
  logic [31:0] modelS;
  logic [31:0] modelOE;
  logic [31:0] lastRead;
  int          assertCount;
  int          failCount;

  wb_gpo_regs #(.DW(32), .S_INIT(32'h0)) dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .CYC_I (CYC_I),
    .STB_I (STB_I),
    .WE_I  (WE_I),
    .ADR_I (ADR_I),
    .SEL_I (SEL_I),
    .DAT_I (DAT_I),
    .DAT_O (DAT_O),
    .ACK_O (ACK_O),
`ifdef WB_GPO_OE_EN
    .OE_O  (OE_O),
`endif
    .S     (S)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] laneMaskOf(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{sel[k]}};
    return m;
  endfunction

  task automatic modelWrite(input logic [2:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    logic [31:0] m;
    m = laneMaskOf(sel);
    case (adr)
      3'd0: modelS = (modelS & ~m) | (dat & m);
      3'd1: modelS = modelS | (dat & m);
      3'd2: modelS = modelS & ~(dat & m);
      3'd3: modelS = modelS ^ (dat & m);
`ifdef WB_GPO_OE_EN
      3'd6: modelOE = (modelOE & ~m) | (dat & m);
`endif
      default: ;
    endcase
  endtask

  function automatic logic [31:0] readModel(input logic [2:0] adr);
    logic [31:0] v;
    v = 32'h0;
    case (adr)
`ifdef WB_GPO_OE_EN
      3'd0, 3'd1, 3'd2, 3'd3: v = modelS & modelOE;
      3'd6:                   v = modelOE;
`else
      3'd0, 3'd1, 3'd2, 3'd3: v = modelS;
`endif
      3'd4:                   v = 32'h0000_00A5;
      default:                v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] adr,
                               input logic [3:0] sel, input logic [31:0] dat, input int mode);
    expT e;
    int  lat;
    bit  acked;
    if (we) begin
      modelWrite(adr, sel, dat);
      e = '{tag, 1'b0, modelS, 2};
    end else begin
      e = '{tag, 1'b1, readModel(adr), 1};
    end
    sbQ.push_back(e);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; SEL_I = sel; DAT_I = dat;
    lat = 0;
    acked = 1'b0;
    while (!acked && lat < 8) begin
      @(posedge CLK_I); #1;
      lat++;
      if (ACK_O) acked = 1'b1;
      else if (lat == 1 && mode == MODE_SCRAMBLE) begin
        ADR_I = ~adr; SEL_I = ~sel; DAT_I = ~dat;
      end else if (lat == 1 && mode == MODE_DROP) begin
        CYC_I = 1'b0; STB_I = 1'b0;
      end
    end
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    e = sbQ.pop_front();
    checkOutput({tag, "_ack"}, 64'(acked), 64'd1);
    if (acked) begin
      checkOutput({tag, "_lat"}, 64'(lat), 64'(e.expLat));
      if (e.isRead) begin
        checkOutput({tag, "_rdata"}, 64'(DAT_O), 64'(e.expData));
        lastRead = e.expData;
      end else begin
        checkOutput({tag, "_s"}, 64'(S), 64'(e.expData));
        checkOutput({tag, "_dato_hold"}, 64'(DAT_O), 64'(lastRead));
      end
    end
    @(posedge CLK_I); #1;
    checkOutput({tag, "_ack_one_cycle"}, 64'(ACK_O), 64'd0);
  endtask

  initial begin
    int  ackCount;
    expT e;
    assertCount = 0;
    failCount   = 0;
    modelS   = 32'h0;
    modelOE  = 32'h0;
    lastRead = 32'h0;
    RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    ADR_I = 3'd0; SEL_I = 4'h0; DAT_I = 32'h0;

    repeat (2) @(posedge CLK_I);
    #1;
    checkOutput("reset_s", 64'(S), 64'h0);
    checkOutput("reset_ack", 64'(ACK_O), 64'h0);
    checkOutput("reset_dato", 64'(DAT_O), 64'h0);
    checkOutput("reset_state", 64'(dut.state_q), 64'h0);
    RST_I = 1'b0;

    $display("[TB] reset during a write to OUT");
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 3'd0; SEL_I = 4'hF; DAT_I = 32'h1234_5678;
    @(posedge CLK_I); #1;
    RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK_I); #1;
      checkOutput("midreset_no_ack", 64'(ACK_O), 64'h0);
    end
    RST_I = 1'b0;
    checkOutput("midreset_s", 64'(S), 64'h0);
    checkOutput("midreset_state", 64'(dut.state_q), 64'h0);
    @(posedge CLK_I); #1;
    checkOutput("midreset_no_late_ack", 64'(ACK_O), 64'h0);

    $display("[TB] direct writes and lane selects");
    applyStimulus("out_full", 1'b1, 3'd0, 4'b1111, 32'hDEAD_BEEF, MODE_NORMAL);
    checkOutput("out_full_const", 64'(S), 64'hDEAD_BEEF);
    applyStimulus("out_lanes", 1'b1, 3'd0, 4'b0101, 32'h1122_3344, MODE_NORMAL);
    checkOutput("out_lanes_const", 64'(S), 64'hDE22_BE44);

    $display("[TB] set / clear / toggle");
    applyStimulus("out_f0", 1'b1, 3'd0, 4'b1111, 32'h0000_00F0, MODE_NORMAL);
    applyStimulus("set", 1'b1, 3'd1, 4'b1111, 32'h0000_000F, MODE_NORMAL);
    checkOutput("set_const", 64'(S), 64'h0000_00FF);
    applyStimulus("clr", 1'b1, 3'd2, 4'b1111, 32'h0000_00C3, MODE_NORMAL);
    checkOutput("clr_const", 64'(S), 64'h0000_003C);
    applyStimulus("tgl", 1'b1, 3'd3, 4'b1111, 32'hFFFF_0000, MODE_NORMAL);
    checkOutput("tgl_const", 64'(S), 64'hFFFF_003C);
    applyStimulus("tgl_lane", 1'b1, 3'd3, 4'b1000, 32'hFFFF_FFFF, MODE_NORMAL);
    applyStimulus("set_lane", 1'b1, 3'd1, 4'b0010, 32'hAAAA_AAAA, MODE_NORMAL);

    $display("[TB] reads and ignored writes");
    applyStimulus("rd_out", 1'b0, 3'd0, 4'hF, 32'h0, MODE_NORMAL);
    applyStimulus("rd_tgl", 1'b0, 3'd3, 4'hF, 32'h0, MODE_NORMAL);
    applyStimulus("rd_id", 1'b0, 3'd4, 4'hF, 32'h0, MODE_NORMAL);
    checkOutput("rd_id_const", 64'(DAT_O), 64'h0000_00A5);
    applyStimulus("rd_adr7", 1'b0, 3'd7, 4'hF, 32'h0, MODE_NORMAL);
    applyStimulus("rd_adr6", 1'b0, 3'd6, 4'hF, 32'h0, MODE_NORMAL);
    applyStimulus("wr_id_ignored", 1'b1, 3'd4, 4'hF, 32'hFFFF_FFFF, MODE_NORMAL);
    applyStimulus("wr_adr5_ignored", 1'b1, 3'd5, 4'hF, 32'h0000_0000, MODE_NORMAL);

    $display("[TB] input changes and strobe drop mid-access");
    applyStimulus("scramble", 1'b1, 3'd0, 4'b0011, 32'h0000_5A5A, MODE_SCRAMBLE);
    applyStimulus("drop_stb", 1'b1, 3'd2, 4'b0001, 32'h0000_0002, MODE_DROP);
    applyStimulus("rd_after", 1'b0, 3'd1, 4'hF, 32'h0, MODE_NORMAL);

    $display("[TB] back-to-back reads with strobe held");
    for (int i = 0; i < 3; i++) sbQ.push_back('{"b2b_rd", 1'b1, readModel(3'd0), 1});
    ackCount = 0;
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 3'd0; SEL_I = 4'hF;
    for (int i = 1; i <= 8; i++) begin
      @(posedge CLK_I); #1;
      if (ACK_O) begin
        ackCount++;
        if (sbQ.size() > 0) begin
          e = sbQ.pop_front();
          checkOutput(e.tag, 64'(DAT_O), 64'(e.expData));
          lastRead = e.expData;
        end
      end
      if (i == 6) begin
        CYC_I = 1'b0; STB_I = 1'b0;
      end
    end
    checkOutput("b2b_ack_count", 64'(ackCount), 64'd3);
    checkOutput("b2b_sb_empty", 64'(sbQ.size()), 64'd0);
    sbQ.delete();

`ifdef WB_GPO_OE_EN
    $display("[TB] output-enable register");
    applyStimulus("oe_wr", 1'b1, 3'd6, 4'hF, 32'h0000_FFFF, MODE_NORMAL);
    applyStimulus("oe_out", 1'b1, 3'd0, 4'hF, 32'hAAAA_5555, MODE_NORMAL);
    checkOutput("oe_s_const", 64'(S), 64'hAAAA_5555);
    checkOutput("oe_port", 64'(OE_O), 64'h0000_FFFF);
    applyStimulus("oe_rd_out", 1'b0, 3'd0, 4'hF, 32'h0, MODE_NORMAL);
    checkOutput("oe_rd_const", 64'(DAT_O), 64'h0000_5555);
    applyStimulus("oe_rd_oe", 1'b0, 3'd6, 4'hF, 32'h0, MODE_NORMAL);
    applyStimulus("oe_lane", 1'b1, 3'd6, 4'b0100, 32'h00FF_0000, MODE_NORMAL);
    checkOutput("oe_lane_port", 64'(OE_O), 64'h00FF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
